// File: rtl/and_gate_if.sv
// Operand, control and result signals of and_gate grouped as one bus.
// The master drives the operands and cnt_clr; the slave (and_gate) drives the results.
`timescale 1ns/1ps

interface and_gate_if #(
  parameter int CNT_W = 16
);
  logic             a;
  logic             b;
  logic             cnt_clr;
  logic             s;
  logic             s_sync;
  logic             s_filt;
  logic             s_rise;
  logic [CNT_W-1:0] s_cnt;

  modport master (
    output a, b, cnt_clr,
    input  s, s_sync, s_filt, s_rise, s_cnt
  );

  modport slave (
    input  a, b, cnt_clr,
    output s, s_sync, s_filt, s_rise, s_cnt
  );
endinterface

// File: rtl/and_gate.sv
// AND of two asynchronous inputs: raw, synchronized, run-length filtered, rising-edge pulse.
// Optional rise-event counter enabled by defining AND_GATE_CNT_EN; otherwise s_cnt is tied to 0.
`timescale 1ns/1ps

module and_gate #(
  parameter int FILT_LEN = 4,   // 1..255
  parameter int CNT_W    = 16   // 1..32, must match the bus CNT_W
) (
  input  logic     sys_clk,
  input  logic     sys_rst_n,
  and_gate_if.slave bus
);

  localparam logic [7:0] FILT_MAX = 8'(FILT_LEN);

  logic [1:0] a_sync;
  logic [1:0] b_sync;
  logic       s_sync;
  logic [7:0] run_cnt;
  logic [7:0] run_nxt;
  logic       filt_nxt;
  logic       rise_nxt;
  logic       s_filt;
  logic       s_rise;

  // Raw AND path: purely combinational, alive even while reset is held.
  assign bus.s = bus.a & bus.b;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the two synchronizer stages.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      a_sync <= 2'b00;
      b_sync <= 2'b00;
    end else begin
      a_sync <= {a_sync[0], bus.a};
      b_sync <= {b_sync[0], bus.b};
    end
  end

  assign s_sync     = a_sync[1] & b_sync[1];
  assign bus.s_sync = s_sync;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    run_nxt  = 8'd0;
    filt_nxt = 1'b0;
    rise_nxt = 1'b0;
    if (s_sync) begin
      run_nxt = (run_cnt == FILT_MAX) ? run_cnt : run_cnt + 8'd1;
    end
    // A saturated run keeps filt_nxt high; any 0 sample drops it at once.
    filt_nxt = s_sync && (run_nxt == FILT_MAX);
    rise_nxt = filt_nxt && !s_filt;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      run_cnt <= 8'd0;
      s_filt  <= 1'b0;
      s_rise  <= 1'b0;
    end else begin
      run_cnt <= run_nxt;
      s_filt  <= filt_nxt;
      s_rise  <= rise_nxt;
    end
  end

  assign bus.s_filt = s_filt;
  assign bus.s_rise = s_rise;

`ifdef AND_GATE_CNT_EN
  logic [CNT_W-1:0] cnt;

  // Clear wins over a coincident rise; the count saturates instead of wrapping.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt <= '0;
    end else if (bus.cnt_clr) begin
      cnt <= '0;
    end else if (s_rise && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign bus.s_cnt = cnt;
`else
  logic cnt_clr_unused;

  assign cnt_clr_unused = bus.cnt_clr;
  assign bus.s_cnt      = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_and_gate.sv
// Self-checking bench for and_gate: two instances (FILT_LEN=4/CNT_W=2 and FILT_LEN=1/CNT_W=16)
// fed the same stimulus, compared every cycle against a sample-history reference model.
`timescale 1ns/1ps

module tb_and_gate;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;

  always #5 sys_clk = ~sys_clk;

  and_gate_if #(.CNT_W(2))  bus4 ();
  and_gate_if #(.CNT_W(16)) bus1 ();

  and_gate #(.FILT_LEN(4), .CNT_W(2)) dut4 (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .bus      (bus4)
  );

  and_gate #(.FILT_LEN(1), .CNT_W(16)) dut1 (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .bus      (bus1)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: a&b as sampled at each clock edge since reset release, newest first.
  bit     ab_hist[$];
  int     flen [2] = '{4, 1};
  longint cmax [2] = '{3, 65535};
  bit     filt_e[2];
  bit     rise_e[2];
  longint cnt_e [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit exp_sync();
    return (ab_hist.size() >= 2) ? ab_hist[1] : 1'b0;
  endfunction

  // s_filt after edge n is high iff s_sync was 1 before each of the last f edges,
  // i.e. a&b was 1 at edges n-f-1 .. n-2.
  function automatic bit window_high(input int f);
    if (ab_hist.size() < f + 2) return 1'b0;
    for (int i = 2; i <= f + 1; i++) if (!ab_hist[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    ab_hist.delete();
    for (int k = 0; k < 2; k++) begin
      filt_e[k] = 1'b0;
      rise_e[k] = 1'b0;
      cnt_e[k]  = 0;
    end
  endtask

  task automatic model_edge();
    bit     nf;
    longint nc;
    if (!sys_rst_n) begin
      model_reset();
      return;
    end
    ab_hist.push_front(bus4.a & bus4.b);
    if (ab_hist.size() > 16) void'(ab_hist.pop_back());
    for (int k = 0; k < 2; k++) begin
      nf = window_high(flen[k]);
`ifdef AND_GATE_CNT_EN
      if (bus4.cnt_clr)                         nc = 0;
      else if (rise_e[k] && cnt_e[k] < cmax[k]) nc = cnt_e[k] + 1;
      else                                      nc = cnt_e[k];
`else
      nc = 0;
`endif
      rise_e[k] = nf && !filt_e[k];
      filt_e[k] = nf;
      cnt_e[k]  = nc;
    end
  endtask

  task automatic check_all();
    check("s4",      32'(bus4.s),      32'(bus4.a & bus4.b));
    check("s1",      32'(bus1.s),      32'(bus1.a & bus1.b));
    check("sync4",   32'(bus4.s_sync), 32'(exp_sync()));
    check("sync1",   32'(bus1.s_sync), 32'(exp_sync()));
    check("filt4",   32'(bus4.s_filt), 32'(filt_e[0]));
    check("filt1",   32'(bus1.s_filt), 32'(filt_e[1]));
    check("rise4",   32'(bus4.s_rise), 32'(rise_e[0]));
    check("rise1",   32'(bus1.s_rise), 32'(rise_e[1]));
    check("cnt4",    32'(bus4.s_cnt),  32'(cnt_e[0]));
    check("cnt1",    32'(bus1.s_cnt),  32'(cnt_e[1]));
  endtask

  task automatic drive(input logic a, input logic b, input logic clr);
    bus4.a = a; bus4.b = b; bus4.cnt_clr = clr;
    bus1.a = a; bus1.b = b; bus1.cnt_clr = clr;
  endtask

  task automatic cycle();
    @(posedge sys_clk);
    model_edge();
    @(negedge sys_clk);
    check_all();
  endtask

  task automatic run(input logic a, input logic b, input int n);
    drive(a, b, 1'b0);
    for (int i = 0; i < n; i++) cycle();
  endtask

  int         n_rise;
  int         wait_cnt;
  int         seg_len;
  logic [1:0] seg_ab;
  int         sat_tbl [5] = '{1, 2, 3, 3, 3};

  initial begin
    model_reset();
    drive(1'b0, 1'b0, 1'b0);

    // Combinational path with reset held: 00,01,10,11,00 at 100 ns steps.
    for (int i = 0; i < 5; i++) begin
      logic [1:0] ab;
      ab = (i == 4) ? 2'b00 : 2'(i);
      drive(ab[1], ab[0], 1'b0);
      #1;
      check_all();
      #99;
    end

    // Release reset on a falling edge, then let everything settle.
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    run(1'b0, 1'b0, 3);

    // Long qualified run followed by idle: exactly one rise per instance.
    n_rise = 0;
    drive(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (bus4.s_rise === 1'b1) n_rise++;
    end
    drive(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (bus4.s_rise === 1'b1) n_rise++;
    end
    check("rise_once", 32'(n_rise), 32'd1);

    // Glitch shorter than FILT_LEN on the 4-deep instance.
    run(1'b1, 1'b1, 3);
    run(1'b1, 1'b0, 6);

    // Clear, then five qualified pulses: the 2-bit count saturates at 3.
    drive(1'b0, 1'b0, 1'b1);
    cycle();
    for (int p = 0; p < 5; p++) begin
      run(1'b1, 1'b1, 8);
      run(1'b0, 1'b0, 4);
`ifdef AND_GATE_CNT_EN
      check("cnt_sat", 32'(bus4.s_cnt), 32'(sat_tbl[p]));
`else
      check("cnt_off", 32'(bus4.s_cnt), 32'd0);
`endif
    end

    // Clear, one pulse (count 1), then assert cnt_clr on the rise cycle of a second pulse.
    drive(1'b0, 1'b0, 1'b1);
    cycle();
    run(1'b1, 1'b1, 8);
    run(1'b0, 1'b0, 4);
    drive(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (rise_e[0]) break;
    end
    check("rise_seen", 32'(bus4.s_rise), 32'd1);
    drive(1'b1, 1'b1, 1'b1);
    cycle();
    check("clr_on_rise", 32'(bus4.s_cnt), 32'd0);
    run(1'b0, 1'b0, 4);

    // Reset pulsed mid-run: registered outputs drop at once, s stays high.
    run(1'b1, 1'b1, 10);
    #2;
    sys_rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    check("s_in_rst", 32'(bus4.s), 32'd1);
    cycle();
    cycle();
    sys_rst_n = 1'b1;
    wait_cnt = 0;
    while (bus4.s_filt !== 1'b1 && wait_cnt < 20) begin
      cycle();
      wait_cnt++;
    end
    check("filt_after_rst", 32'(wait_cnt), 32'd6);
    run(1'b0, 1'b0, 4);

    // Randomized segments with occasional clears and asynchronous resets.
    for (int seg = 0; seg < 120; seg++) begin
      seg_ab  = 2'($urandom_range(0, 3));
      seg_len = $urandom_range(1, 9);
      if ($urandom_range(0, 24) == 0) begin
        #2;
        sys_rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        cycle();
        sys_rst_n = 1'b1;
      end
      for (int i = 0; i < seg_len; i++) begin
        drive(seg_ab[1], seg_ab[0], 1'($urandom_range(0, 15) == 0));
        cycle();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
